// File: rtl/mapper_arb_pkg.sv
// Shared types for the mapper memory arbiter.
// Grant tracking, FSM states and the captured request bundle.
package mapper_arb_pkg;

  localparam int ARB_ADDR_W = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    LD_ACC  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_LD  = 1'b1
  } arb_grant_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [7:0]            wdata;
  } arb_req_t;

endpackage

// File: rtl/mapper_arb_watchdog.sv
// Busy-cycle counter for the memory arbiter.
// Pulses expire on the last allowed cycle of an access.
module mapper_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // count busy cycles, restart whenever the bus is idle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = run & (cnt == LAST);

endmodule

// File: rtl/mapper_mem_arbiter.sv
// Shares the external memory port between CPU and ROM loader.
// Round-robin on ties, one idle cycle between accesses.
module mapper_mem_arbiter
  import mapper_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_busy,
  output logic              ld_overrun,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout
);

  arb_state_t state;
  arb_grant_t last_grant;
  arb_req_t   cpu_req;
  arb_req_t   ld_req;
  arb_req_t   cur;

  logic cpu_cs_q;
  logic cpu_pend;
  logic ld_pend;
  logic cs_rise;
  logic ld_take;
  logic busy;
  logic expire;
  logic done;
  logic cpu_done;
  logic ld_done;
  logic pick_cpu;

  assign cs_rise  = cpu_cs & ~cpu_cs_q;
  assign ld_take  = ld_wr & ~ld_pend;
  assign busy     = (state != IDLE);
  assign done     = busy & (mem_ack | expire);
  assign cpu_done = done & (state == CPU_ACC);
  assign ld_done  = done & (state == LD_ACC);
  assign pick_cpu = cpu_pend &
                    (~ld_pend | (last_grant == GRANT_LD));

  mapper_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (~busy),
    .run     (busy & ~mem_ack),
    .expire  (expire)
  );

  // capture requests; a new cs rise re-arms even mid-service
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_cs_q   <= 1'b0;
      cpu_pend   <= 1'b0;
      ld_pend    <= 1'b0;
      ld_overrun <= 1'b0;
      cpu_req    <= '0;
      ld_req     <= '0;
    end else begin
      cpu_cs_q <= cpu_cs;
      cpu_pend <= cs_rise | (cpu_pend & ~cpu_done);
      ld_pend  <= ld_take | (ld_pend & ~ld_done);
      if (ld_wr & ld_pend) begin
        ld_overrun <= 1'b1;
      end
      if (cs_rise) begin
        cpu_req <= '{
          we:    cpu_we,
          addr:  ARB_ADDR_W'(cpu_addr),
          wdata: cpu_wdata
        };
      end
      if (ld_take) begin
        ld_req <= '{
          we:    1'b1,
          addr:  ARB_ADDR_W'(ld_addr),
          wdata: ld_wdata
        };
      end
    end
  end

  // grant, run the access, finish on ack or watchdog
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_LD;
      cur         <= '0;
      cpu_rdata   <= 8'hFF;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= done & ~mem_ack;
      unique case (state)
        IDLE: begin
          if (pick_cpu) begin
            state      <= CPU_ACC;
            last_grant <= GRANT_CPU;
            cur        <= cpu_req;
          end else if (ld_pend) begin
            state      <= LD_ACC;
            last_grant <= GRANT_LD;
            cur        <= ld_req;
          end
        end
        CPU_ACC: begin
          if (done) begin
            state <= IDLE;
            if (!cur.we) begin
              cpu_rdata <= mem_ack ? mem_rdata : 8'hFF;
            end
          end
        end
        LD_ACC: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = cur.we;
  assign mem_addr  = ADDR_W'(cur.addr);
  assign mem_wdata = cur.wdata;
  assign cpu_wait  = cs_rise | cpu_pend;
  assign ld_busy   = ld_pend;

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Bench for mapper_mem_arbiter: random CPU/loader traffic,
// memory responder with random latency, scoreboard of accesses.
module tb_mapper_mem_arbiter;

  localparam int AW = 27;
  localparam int TO = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_cs = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_wait;
  logic          ld_wr = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_wdata = '0;
  logic          ld_busy;
  logic          ld_overrun;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          err_timeout;

  mapper_mem_arbiter #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cpu_cs      (cpu_cs),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_wait    (cpu_wait),
    .ld_wr       (ld_wr),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_busy     (ld_busy),
    .ld_overrun  (ld_overrun),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err_timeout (err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit            ld;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } acc_t;

  acc_t exp_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_rdata = 8'hFF;
  bit         exp_ovr = 1'b0;
  bit         last_ld = 1'b1;
  int         force_d = -1;
  int         force_rv = -1;
  bit         stale = 1'b0;
  bit         m_busy = 1'b0;
  int         m_chk = 0;
  int         m_n = 0;
  int         m_d = 0;
  logic [7:0] m_rv = '0;
  acc_t       m_cur;
  int         wait_exp = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int pick_d();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return r % 3;
    if (r == 7) return TO - 1;
    return TO;
  endfunction

  // memory responder and scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (!reset_n) begin
        m_busy = 1'b0;
        m_chk = 0;
        continue;
      end
      if (m_chk != 0) begin
        check("req_drop", mem_req, 1'b0);
        check("err_timeout", err_timeout, m_chk == 2);
        if (!m_cur.ld) begin
          if (!m_cur.we)
            exp_rdata = (m_chk == 1) ? m_rv : 8'hFF;
          check("cpu_rdata", cpu_rdata, exp_rdata);
          check("cpu_wait_clr", cpu_wait, 1'b0);
        end else begin
          check("ld_busy_clr", ld_busy, 1'b0);
        end
        m_chk = 0;
      end else begin
        check("err_quiet", err_timeout, 1'b0);
      end
      if (stale && !m_busy) begin
        mem_ack = 1'b1;
        stale = 1'b0;
      end
      if (!m_busy && mem_req) begin
        check("req_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() == 0) begin
          m_cur.ld = 1'b1;
          m_cur.we = mem_we;
        end else begin
          m_cur = exp_q.pop_front();
          check("mem_we", mem_we, m_cur.we);
          check("mem_addr", mem_addr, m_cur.addr);
          check("mem_wdata", mem_wdata, m_cur.wdata);
        end
        m_d = (force_d >= 0) ? force_d : pick_d();
        m_rv = (force_rv >= 0) ? 8'(force_rv)
                               : 8'($urandom);
        force_d = -1;
        force_rv = -1;
        m_busy = 1'b1;
        m_n = 0;
        if (!m_cur.ld)
          wait_exp = (m_d < TO) ? 3 + m_d : 2 + TO;
      end
      if (m_busy) begin
        m_n++;
        if (m_n > 1) check("req_hold", mem_req, 1'b1);
        if (m_d < TO && m_n == m_d + 1) begin
          mem_ack = 1'b1;
          mem_rdata = m_rv;
          m_chk = 1;
          m_busy = 1'b0;
        end else if (m_n == TO) begin
          m_chk = 2;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic push(input bit ld, input bit we,
                      input logic [AW-1:0] a,
                      input logic [7:0] d);
    acc_t t;
    t.ld = ld;
    t.we = we;
    t.addr = a;
    t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_sys);
      if (!cpu_wait && !ld_busy && !mem_req &&
          !m_busy && m_chk == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    check("cpu_rdata_hold", cpu_rdata, exp_rdata);
    check("ld_overrun", ld_overrun, exp_ovr);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 8'hFF);
    check({tag, "_cpu_wait"}, cpu_wait, 1'b0);
    check({tag, "_ld_busy"}, ld_busy, 1'b0);
    check({tag, "_ld_overrun"}, ld_overrun, 1'b0);
    check({tag, "_err"}, err_timeout, 1'b0);
  endtask

  task automatic cpu_op(input bit we,
                        input logic [AW-1:0] a,
                        input logic [7:0] d,
                        input bit hold);
    int w;
    bit fell;
    @(negedge clk_sys);
    cpu_cs = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    push(1'b0, we, a, d);
    last_ld = 1'b0;
    #1 check("wait_first", cpu_wait, 1'b1);
    w = 1;
    fell = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(negedge clk_sys);
      if (cpu_wait) w++;
      else fell = 1'b1;
      if (!hold) begin
        cpu_cs = 1'b0;
        cpu_addr = AW'($urandom);
        cpu_wdata = 8'($urandom);
      end
    end
    cpu_cs = 1'b0;
    check("wait_cycles", w, wait_exp);
    wait_idle();
  endtask

  task automatic ld_op(input logic [AW-1:0] a,
                       input logic [7:0] d,
                       input bit ovr,
                       input logic [AW-1:0] a2);
    @(negedge clk_sys);
    ld_wr = 1'b1;
    ld_addr = a;
    ld_wdata = d;
    push(1'b1, 1'b1, a, d);
    last_ld = 1'b1;
    @(negedge clk_sys);
    check("ld_busy_set", ld_busy, 1'b1);
    if (ovr) begin
      ld_addr = a2;
      ld_wdata = ~d;
      exp_ovr = 1'b1;
      @(negedge clk_sys);
    end
    ld_wr = 1'b0;
    ld_addr = AW'($urandom);
    wait_idle();
  endtask

  task automatic pair_op(input bit we,
                         input logic [AW-1:0] ca,
                         input logic [7:0] cd,
                         input logic [AW-1:0] la,
                         input logic [7:0] ldd);
    @(negedge clk_sys);
    cpu_cs = 1'b1;
    cpu_we = we;
    cpu_addr = ca;
    cpu_wdata = cd;
    ld_wr = 1'b1;
    ld_addr = la;
    ld_wdata = ldd;
    if (last_ld) begin
      push(1'b0, we, ca, cd);
      push(1'b1, 1'b1, la, ldd);
      last_ld = 1'b1;
    end else begin
      push(1'b1, 1'b1, la, ldd);
      push(1'b0, we, ca, cd);
      last_ld = 1'b0;
    end
    @(negedge clk_sys);
    ld_wr = 1'b0;
    for (int i = 0; i < 60 && cpu_wait; i++)
      @(negedge clk_sys);
    cpu_cs = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    check_reset("por");
    reset_n = 1'b1;

    force_d = 0;
    cpu_op(1'b1, 27'h00123, 8'hC3, 1'b0);
    check("wr_keeps_rdata", cpu_rdata, 8'hFF);

    force_d = 1;
    force_rv = 8'h5A;
    cpu_op(1'b0, 27'h04000, 8'h00, 1'b1);
    check("rd_data", cpu_rdata, 8'h5A);

    ld_op(27'h00100, 8'h11, 1'b0, '0);
    pair_op(1'b1, 27'h00200, 8'h22, 27'h00300, 8'h33);
    pair_op(1'b0, 27'h00400, 8'h44, 27'h00500, 8'h55);

    ld_op(27'h0, 8'hA0, 1'b1, 27'h1);
    check("overrun_sticky", ld_overrun, 1'b1);

    force_d = TO;
    cpu_op(1'b0, 27'h00600, 8'h00, 1'b1);
    check("wd_rdata_ff", cpu_rdata, 8'hFF);
    force_d = TO - 1;
    force_rv = 8'h3C;
    cpu_op(1'b0, 27'h00700, 8'h00, 1'b1);
    check("wd_ack_wins", cpu_rdata, 8'h3C);

    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: cpu_op(1'($urandom), AW'($urandom),
                  8'($urandom), 1'($urandom));
        1: ld_op(AW'($urandom), 8'($urandom),
                 1'b0, '0);
        2: ld_op(AW'($urandom), 8'($urandom),
                 1'b1, AW'($urandom));
        default: pair_op(1'($urandom), AW'($urandom),
                         8'($urandom), AW'($urandom),
                         8'($urandom));
      endcase
    end

    force_d = TO;
    @(negedge clk_sys);
    ld_wr = 1'b1;
    ld_addr = 27'h00800;
    ld_wdata = 8'h88;
    push(1'b1, 1'b1, 27'h00800, 8'h88);
    @(negedge clk_sys);
    ld_wr = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++)
      @(negedge clk_sys);
    check("rst_req_seen", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_rdata = 8'hFF;
    exp_ovr = 1'b0;
    last_ld = 1'b1;
    force_d = -1;
    #1 check_reset("arst");
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    stale = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("stale_no_req", mem_req, 1'b0);
    check("stale_rdata", cpu_rdata, 8'hFF);
    check("stale_busy", ld_busy, 1'b0);
    pair_op(1'b0, 27'h00900, 8'h00, 27'h00A00, 8'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
